btb_access_ctrl: RTL and testbench

// - Sole access port to the single-ported BTB: shares it between the fetch-stage predict requester and the execute-stage resolve requester.
// - Buffers resolves in a FIFO and issues at most one BTB op per cycle (predict or resolve).
// - Drives the BTB enable/predict/resolve strobes and returns the 1-cycle-latency predict response to fetch.

---
 rtl/btb_access_ctrl_pkg.sv | 16 +
 rtl/btb_res_fifo.sv | 64 ++++++
 rtl/btb_access_ctrl.sv | 177 +++++++++++++++++
 tb/tb_btb_access_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_access_ctrl_pkg.sv
// Package: btb_access_ctrl_pkg
// Purpose: shared types and helpers for the BTB access controller.
//   - mode_e      : arbitration mode (NORMAL favours fetch, DRAIN empties the resolve FIFO)
//   - entry_width : width of one resolve FIFO entry laid out as {pc[W], hit, target[W]}
package btb_access_ctrl_pkg;

    typedef enum logic {
        MODE_NORMAL = 1'b0,
        MODE_DRAIN  = 1'b1
    } mode_e;

    function automatic int entry_width(input int w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/btb_res_fifo.sv
// Module: btb_res_fifo
// Purpose: synchronous FIFO holding accepted taken resolves until the BTB port is free.
// Ports:
//   clk, rst           clock; asynchronous active-low reset (empties the FIFO)
//   push, push_data    write one entry (ignored when full)
//   pop                drop the head entry (ignored when empty)
//   head_data          current head entry (valid when !empty)
//   full, empty, occ   registered occupancy status
module btb_res_fifo #(
    parameter int DATA_W = 65,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     occ
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full      = (occ == DEPTH_OCC);
    assign empty     = (occ == '0);
    assign push_ok   = push & ~full;
    assign pop_ok    = pop & ~empty;
    assign head_data = mem[rd_ptr];

    // Storage needs no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            occ <= occ + OCC_W'(push_ok) - OCC_W'(pop_ok);
        end
    end

endmodule

// File: rtl/btb_access_ctrl.sv
// Module: btb_access_ctrl
// Purpose: sole access port to the single-ported BTB. Arbitrates, one op per
// cycle, between fetch predicts and buffered execute resolves, and returns the
// 1-cycle-latency predict response to fetch.
// Ports:
//   clk, rst                         clock; asynchronous active-low reset
//   pred_req, pred_pc, pred_ready    fetch predict request / grant
//   flush                            kills the in-flight predict response
//   pred_rsp_valid/hit/target        predict response to fetch
//   res_valid/ready, res_pc, res_taken, res_hit, res_target   resolve offer
//   btb_en, btb_predict, btb_resolve, btb_pc_addr, btb_pr_*   BTB command
//   btb_hit, btb_target, btb_out_valid                        BTB registered outputs
//   stall_cnt                        cycles where fetch requested but was refused
module btb_access_ctrl
    import btb_access_ctrl_pkg::*;
#(
    parameter int W          = 32,
    parameter int RQ_DEPTH   = 4,
    parameter int HI_WM      = 3,
    parameter int LO_WM      = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pred_req,
    input  logic [W-1:0] pred_pc,
    output logic         pred_ready,
    input  logic         flush,
    output logic         pred_rsp_valid,
    output logic         pred_rsp_hit,
    output logic [W-1:0] pred_rsp_target,
    input  logic         res_valid,
    output logic         res_ready,
    input  logic [W-1:0] res_pc,
    input  logic         res_taken,
    input  logic         res_hit,
    input  logic [W-1:0] res_target,
    output logic         btb_en,
    output logic         btb_predict,
    output logic         btb_resolve,
    output logic [W-1:0] btb_pc_addr,
    output logic         btb_pr_br_taken,
    output logic         btb_pr_hit,
    output logic [W-1:0] btb_pr_target,
    input  logic         btb_hit,
    input  logic [W-1:0] btb_target,
    input  logic         btb_out_valid,
    output logic [31:0]  stall_cnt
);

    localparam int EW       = entry_width(W);
    localparam int OCC_W    = $clog2(RQ_DEPTH) + 1;
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [OCC_W-1:0]    HI_OCC     = OCC_W'(HI_WM);
    localparam logic [OCC_W-1:0]    LO_OCC     = OCC_W'(LO_WM);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    mode_e                mode_q;
    mode_e                mode_d;
    logic [STARVE_W-1:0]  starve;
    logic                 inflight;
    logic                 pred_grant;
    logic                 res_grant;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [OCC_W-1:0]     occ;
    logic                 push;
    logic [EW-1:0]        head_data;
    logic [W-1:0]         head_pc;
    logic                 head_hit;
    logic [W-1:0]         head_target;

    // Not-taken resolves are acknowledged but never stored: the BTB ignores them.
    assign res_ready = rst & ~fifo_full;
    assign push      = res_valid & res_ready & res_taken;
    assign {head_pc, head_hit, head_target} = head_data;

    btb_res_fifo #(
        .DATA_W (EW),
        .DEPTH  (RQ_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({res_pc, res_hit, res_target}),
        .pop       (res_grant),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occ       (occ)
    );

    // Arbiter and BTB command. Because the FIFO is registered, a resolve can
    // only issue from an entry accepted on an earlier cycle.
    always_comb begin
        pred_grant      = 1'b0;
        res_grant       = 1'b0;
        btb_en          = 1'b0;
        btb_predict     = 1'b0;
        btb_resolve     = 1'b0;
        btb_pc_addr     = '0;
        btb_pr_br_taken = 1'b0;
        btb_pr_hit      = 1'b0;
        btb_pr_target   = '0;
        if (rst) begin
            if (mode_q == MODE_DRAIN) begin
                res_grant = ~fifo_empty;
            end else if ((starve == STARVE_LIM) && !fifo_empty) begin
                res_grant = 1'b1;
            end else begin
                pred_grant = pred_req;
                res_grant  = ~pred_req & ~fifo_empty;
            end
        end
        if (pred_grant) begin
            btb_en      = 1'b1;
            btb_predict = 1'b1;
            btb_pc_addr = pred_pc;
        end else if (res_grant) begin
            btb_en          = 1'b1;
            btb_resolve     = 1'b1;
            btb_pc_addr     = head_pc;
            btb_pr_br_taken = 1'b1;
            btb_pr_hit      = head_hit;
            btb_pr_target   = head_target;
        end
    end

    assign pred_ready      = pred_grant;
    assign pred_rsp_valid  = inflight & btb_out_valid & ~flush;
    assign pred_rsp_hit    = pred_rsp_valid & btb_hit;
    assign pred_rsp_target = pred_rsp_valid ? btb_target : '0;

    // Mode next-state works from registered occupancy, so DRAIN starts one
    // cycle after the high watermark is reached.
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            MODE_NORMAL: if (occ >= HI_OCC) mode_d = MODE_DRAIN;
            MODE_DRAIN:  if (occ <= LO_OCC) mode_d = MODE_NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= MODE_NORMAL;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Starvation counter saturates so the forced-resolve condition stays
    // asserted until the resolve actually issues.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve <= '0;
        end else if (res_grant || fifo_empty) begin
            starve <= '0;
        end else if (starve != STARVE_LIM) begin
            starve <= starve + 1'b1;
        end
    end

    // In-flight predict tracking and fetch stall statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            inflight <= pred_grant & ~flush;
            if (pred_req && !pred_grant) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_btb_access_ctrl.sv
// Testbench: tb_btb_access_ctrl
// Drives btb_access_ctrl against a behavioural BTB, checks every cycle against a
// queue-based reference model, plus a directed vector table and hand sequences.
module tb_btb_access_ctrl;

    localparam int DEPTH = 4;
    localparam int HI    = 3;
    localparam int LO    = 1;
    localparam int SMAX  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_req, flush, res_valid, res_taken, res_hit;
    logic [31:0] pred_pc, res_pc, res_target;
    logic        pred_ready, pred_rsp_valid, pred_rsp_hit, res_ready;
    logic [31:0] pred_rsp_target, btb_pc_addr, btb_pr_target, stall_cnt;
    logic        btb_en, btb_predict, btb_resolve, btb_pr_br_taken, btb_pr_hit;
    logic        btb_hit, btb_out_valid;
    logic [31:0] btb_target;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        pred_req;
        logic [31:0] pred_pc;
        logic        flush;
        logic        res_valid;
        logic [31:0] res_pc;
        logic        res_taken;
        logic        res_hit;
        logic [31:0] res_target;
        logic        e_pred_ready;
        logic        e_res_ready;
        logic        e_btb_resolve;
        logic        e_rsp_valid;
        logic        e_rsp_hit;
        logic [31:0] e_rsp_target;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic [31:0] tgt;
    } ent_t;

    // reference model state
    ent_t        q[$];
    bit          m_drain;
    int          m_starve;
    bit          m_inflight;
    logic [31:0] m_stall;
    bit          m_rsp_hit;
    logic [31:0] m_rsp_tgt;
    logic [31:0] marr [logic [31:0]];
    logic [31:0] env_arr [logic [31:0]];

    vec_t tbl [19];
    vec_t idle;

    btb_access_ctrl dut (
        .clk(clk), .rst(rst),
        .pred_req(pred_req), .pred_pc(pred_pc), .pred_ready(pred_ready),
        .flush(flush),
        .pred_rsp_valid(pred_rsp_valid), .pred_rsp_hit(pred_rsp_hit),
        .pred_rsp_target(pred_rsp_target),
        .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc),
        .res_taken(res_taken), .res_hit(res_hit), .res_target(res_target),
        .btb_en(btb_en), .btb_predict(btb_predict), .btb_resolve(btb_resolve),
        .btb_pc_addr(btb_pc_addr), .btb_pr_br_taken(btb_pr_br_taken),
        .btb_pr_hit(btb_pr_hit), .btb_pr_target(btb_pr_target),
        .btb_hit(btb_hit), .btb_target(btb_target), .btb_out_valid(btb_out_valid),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural single-ported BTB with registered outputs; garbage on
    // hit/target when idle so the controller's output gating is exercised.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            btb_out_valid <= 1'b0;
            btb_hit       <= 1'b0;
            btb_target    <= '0;
        end else begin
            btb_out_valid <= btb_en & btb_predict;
            if (btb_en && btb_predict) begin
                btb_hit    <= env_arr.exists(btb_pc_addr);
                btb_target <= env_arr.exists(btb_pc_addr) ? env_arr[btb_pc_addr] : 32'd0;
            end else begin
                btb_hit    <= 1'($urandom_range(0, 1));
                btb_target <= $urandom;
            end
            if (btb_en && btb_resolve && btb_pr_br_taken) begin
                env_arr[btb_pc_addr] = btb_pr_target;
            end
        end
    end

    function automatic vec_t mk(input logic pr, input logic [31:0] ppc, input logic fl,
                                input logic rv, input logic [31:0] rpc, input logic rt,
                                input logic [31:0] rtg, input logic epr, input logic err,
                                input logic eres, input logic erv, input logic erh,
                                input logic [31:0] ert);
        vec_t v;
        v.pred_req = pr; v.pred_pc = ppc; v.flush = fl;
        v.res_valid = rv; v.res_pc = rpc; v.res_taken = rt; v.res_hit = 1'b0;
        v.res_target = rtg;
        v.e_pred_ready = epr; v.e_res_ready = err; v.e_btb_resolve = eres;
        v.e_rsp_valid = erv; v.e_rsp_hit = erh; v.e_rsp_target = ert;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        q.delete();
        m_drain    = 1'b0;
        m_starve   = 0;
        m_inflight = 1'b0;
        m_stall    = '0;
    endtask

    // Drive one cycle's inputs, check all outputs against the model, then
    // advance the model to the state after the coming rising edge.
    task automatic driveCheck(input vec_t v);
        bit          e_pg, e_rg, e_rr, e_rv, nxt_inflight;
        int          sz;
        logic [31:0] e_pc, e_prt;
        logic        e_prh;
        ent_t        e;
        pred_req = v.pred_req; pred_pc = v.pred_pc; flush = v.flush;
        res_valid = v.res_valid; res_pc = v.res_pc; res_taken = v.res_taken;
        res_hit = v.res_hit; res_target = v.res_target;
        #1;
        sz   = q.size();
        e_rr = (sz < DEPTH);
        e_pg = 1'b0;
        e_rg = 1'b0;
        if (m_drain) e_rg = (sz > 0);
        else if (m_starve == SMAX && sz > 0) e_rg = 1'b1;
        else begin
            e_pg = v.pred_req;
            e_rg = !v.pred_req && sz > 0;
        end
        e_pc = 32'd0; e_prh = 1'b0; e_prt = 32'd0;
        if (e_pg) e_pc = v.pred_pc;
        else if (e_rg) begin
            e_pc = q[0].pc; e_prh = q[0].hit; e_prt = q[0].tgt;
        end
        e_rv = m_inflight && btb_out_valid && !v.flush;
        checkOutput("pred_ready", pred_ready, e_pg);
        checkOutput("res_ready", res_ready, e_rr);
        checkOutput("btb_en", btb_en, e_pg | e_rg);
        checkOutput("btb_predict", btb_predict, e_pg);
        checkOutput("btb_resolve", btb_resolve, e_rg);
        checkOutput("btb_pc_addr", btb_pc_addr, e_pc);
        checkOutput("btb_pr_br_taken", btb_pr_br_taken, e_rg);
        checkOutput("btb_pr_hit", btb_pr_hit, e_prh);
        checkOutput("btb_pr_target", btb_pr_target, e_prt);
        checkOutput("rsp_valid", pred_rsp_valid, e_rv);
        checkOutput("rsp_hit", pred_rsp_hit, e_rv ? m_rsp_hit : 1'b0);
        checkOutput("rsp_target", pred_rsp_target, e_rv ? m_rsp_tgt : 32'd0);
        checkOutput("stall_cnt", stall_cnt, m_stall);
        nxt_inflight = e_pg && !v.flush;
        if (e_pg) begin
            m_rsp_hit = marr.exists(v.pred_pc);
            m_rsp_tgt = m_rsp_hit ? marr[v.pred_pc] : 32'd0;
        end
        if (e_rg) marr[q[0].pc] = q[0].tgt;
        if (e_rg || sz == 0) m_starve = 0;
        else if (m_starve < SMAX) m_starve++;
        if (!m_drain && sz >= HI) m_drain = 1'b1;
        else if (m_drain && sz <= LO) m_drain = 1'b0;
        if (e_rg) void'(q.pop_front());
        if (v.res_valid && e_rr && v.res_taken) begin
            e.pc = v.res_pc; e.hit = v.res_hit; e.tgt = v.res_target;
            q.push_back(e);
        end
        if (v.pred_req && !e_pg) m_stall = m_stall + 32'd1;
        m_inflight = nxt_inflight;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        driveCheck(v);
    endtask

    // Asynchronous reset between edges, with whatever inputs are currently held.
    task automatic resetPulse(input string tag);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput({tag, "_pred_ready"}, pred_ready, 1'b0);
        checkOutput({tag, "_res_ready"}, res_ready, 1'b0);
        checkOutput({tag, "_btb_en"}, btb_en, 1'b0);
        checkOutput({tag, "_rsp_valid"}, pred_rsp_valid, 1'b0);
        checkOutput({tag, "_stall_cnt"}, stall_cnt, 32'd0);
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        driveCheck(idle);
    endtask

    initial begin
        vec_t v;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        rst = 1'b0;
        pred_req = 1'b1; pred_pc = 32'h40; flush = 1'b0;
        res_valid = 1'b1; res_pc = 32'h40; res_taken = 1'b1; res_hit = 1'b0; res_target = 32'h100;
        modelReset();

        // row: inputs ; pred_ready res_ready btb_resolve rsp_valid rsp_hit rsp_target
        tbl[0]  = mk(0, 32'h0,    0, 1, 32'h40,  1, 32'h100, 0, 1, 0, 0, 0, 32'h0);
        tbl[1]  = mk(0, 32'h0,    0, 0, 32'h0,   0, 32'h0,   0, 1, 1, 0, 0, 32'h0);
        tbl[2]  = mk(1, 32'h40,   0, 0, 32'h0,   0, 32'h0,   1, 1, 0, 0, 0, 32'h0);
        tbl[3]  = mk(0, 32'h0,    0, 0, 32'h0,   0, 32'h0,   0, 1, 0, 1, 1, 32'h100);
        tbl[4]  = mk(1, 32'h80,   0, 0, 32'h0,   0, 32'h0,   1, 1, 0, 0, 0, 32'h0);
        tbl[5]  = mk(1, 32'h40,   0, 0, 32'h0,   0, 32'h0,   1, 1, 0, 1, 0, 32'h0);
        tbl[6]  = mk(0, 32'h0,    1, 0, 32'h0,   0, 32'h0,   0, 1, 0, 0, 0, 32'h0);
        tbl[7]  = mk(0, 32'h0,    0, 1, 32'h44,  0, 32'h999, 0, 1, 0, 0, 0, 32'h0);
        tbl[8]  = mk(0, 32'h0,    0, 0, 32'h0,   0, 32'h0,   0, 1, 0, 0, 0, 32'h0);
        tbl[9]  = mk(1, 32'h1000, 0, 1, 32'h200, 1, 32'h300, 1, 1, 0, 0, 0, 32'h0);
        tbl[10] = mk(1, 32'h1000, 0, 1, 32'h204, 1, 32'h304, 1, 1, 0, 1, 0, 32'h0);
        tbl[11] = mk(1, 32'h1000, 0, 1, 32'h208, 1, 32'h308, 1, 1, 0, 1, 0, 32'h0);
        tbl[12] = mk(1, 32'h1000, 0, 1, 32'h20c, 1, 32'h30c, 1, 1, 0, 1, 0, 32'h0);
        tbl[13] = mk(1, 32'h1000, 0, 1, 32'h210, 1, 32'h310, 0, 0, 1, 1, 0, 32'h0);
        tbl[14] = mk(1, 32'h1000, 0, 1, 32'h210, 1, 32'h310, 0, 1, 1, 0, 0, 32'h0);
        tbl[15] = mk(1, 32'h1000, 0, 0, 32'h0,   0, 32'h0,   0, 1, 1, 0, 0, 32'h0);
        tbl[16] = mk(1, 32'h1000, 0, 0, 32'h0,   0, 32'h0,   0, 1, 1, 0, 0, 32'h0);
        tbl[17] = mk(1, 32'h1000, 0, 0, 32'h0,   0, 32'h0,   0, 1, 1, 0, 0, 32'h0);
        tbl[18] = mk(1, 32'h1000, 0, 0, 32'h0,   0, 32'h0,   1, 1, 0, 0, 0, 32'h0);

        // Outputs held at zero while in reset, even with requests pending.
        #3;
        checkOutput("rst_pred_ready", pred_ready, 1'b0);
        checkOutput("rst_res_ready", res_ready, 1'b0);
        checkOutput("rst_btb_en", btb_en, 1'b0);
        checkOutput("rst_rsp_valid", pred_rsp_valid, 1'b0);
        checkOutput("rst_stall_cnt", stall_cnt, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        driveCheck(idle);

        // Directed vector table: resolve/predict hit, flush, not-taken, full, drain.
        for (int i = 0; i < 19; i++) begin
            applyStimulus(tbl[i]);
            checkOutput($sformatf("tbl%0d_pred_ready", i), pred_ready, tbl[i].e_pred_ready);
            checkOutput($sformatf("tbl%0d_res_ready", i), res_ready, tbl[i].e_res_ready);
            checkOutput($sformatf("tbl%0d_btb_resolve", i), btb_resolve, tbl[i].e_btb_resolve);
            checkOutput($sformatf("tbl%0d_rsp_valid", i), pred_rsp_valid, tbl[i].e_rsp_valid);
            checkOutput($sformatf("tbl%0d_rsp_hit", i), pred_rsp_hit, tbl[i].e_rsp_hit);
            checkOutput($sformatf("tbl%0d_rsp_target", i), pred_rsp_target, tbl[i].e_rsp_target);
        end
        checkOutput("tbl_stall_total", stall_cnt, 32'd5);

        // Starvation: one resolve under continuous predicts is forced on cycle 9.
        resetPulse("rst_a");
        applyStimulus(mk(1, 32'h900, 0, 1, 32'h500, 1, 32'h600, 1, 1, 0, 0, 0, 0));
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(mk(1, 32'h900, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
            checkOutput($sformatf("starve_hold%0d", i), btb_resolve, 1'b0);
        end
        applyStimulus(mk(1, 32'h900, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        checkOutput("starve_forced", btb_resolve, 1'b1);
        checkOutput("starve_pred_ready", pred_ready, 1'b0);
        applyStimulus(mk(1, 32'h900, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        checkOutput("starve_stall_cnt", stall_cnt, 32'd1);

        // Reset with two entries queued: nothing issues after release.
        applyStimulus(mk(1, 32'h900, 0, 1, 32'h700, 1, 32'h800, 1, 1, 0, 0, 0, 0));
        applyStimulus(mk(1, 32'h900, 0, 1, 32'h704, 1, 32'h804, 1, 1, 0, 0, 0, 0));
        resetPulse("rst_b");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(idle);
            checkOutput($sformatf("post_rst_btb_en%0d", i), btb_en, 1'b0);
        end

        // Randomised traffic against the reference model.
        for (int i = 0; i < 1500; i++) begin
            v = idle;
            v.pred_req   = ($urandom_range(0, 99) < 65);
            v.pred_pc    = 32'h100 + 32'($urandom_range(0, 7)) * 32'd4;
            v.flush      = ($urandom_range(0, 99) < 10);
            v.res_valid  = ($urandom_range(0, 99) < 45);
            v.res_pc     = 32'h100 + 32'($urandom_range(0, 7)) * 32'd4;
            v.res_taken  = ($urandom_range(0, 99) < 75);
            v.res_hit    = 1'($urandom_range(0, 1));
            v.res_target = $urandom;
            applyStimulus(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
